// File: rtl/rv32_pkg.sv
// Shared RV32 constants used by the EX-stage multiply/divide unit:
// M-extension funct3 codes, multi-cycle FSM states and divide special results.
package rv32_pkg;

    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    localparam logic [31:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for the multiply/divide unit: operand magnitudes at accept time,
// and sign correction plus output-word selection in the FIX state.
module muldiv_sign_fix
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   data_1,
    input  logic [DATA_WIDTH-1:0]   data_2,
    output logic                    sign_1,
    output logic                    sign_2,
    output logic [DATA_WIDTH-1:0]   mag_1,
    output logic [DATA_WIDTH-1:0]   mag_2,
    input  logic [2:0]              fix_funct3,
    input  logic                    fix_sign_1,
    input  logic                    fix_sign_2,
    input  logic [2*DATA_WIDTH-1:0] product,
    input  logic [DATA_WIDTH-1:0]   quotient,
    input  logic [DATA_WIDTH-1:0]   remainder,
    output logic [DATA_WIDTH-1:0]   result
);

    logic op1_signed;
    logic op2_signed;
    logic [2*DATA_WIDTH-1:0] prod_fixed;
    logic [DATA_WIDTH-1:0]   quo_fixed;
    logic [DATA_WIDTH-1:0]   rem_fixed;

    // MULHSU treats only rs1 as signed; the U variants treat neither.
    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (funct3)
            M_MUL, M_MULH, M_DIV, M_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            M_MULHSU: op1_signed = 1'b1;
            default: ;
        endcase
    end

    assign sign_1 = op1_signed & data_1[DATA_WIDTH-1];
    assign sign_2 = op2_signed & data_2[DATA_WIDTH-1];
    assign mag_1  = sign_1 ? -data_1 : data_1;
    assign mag_2  = sign_2 ? -data_2 : data_2;

    always_comb begin
        prod_fixed = (fix_sign_1 ^ fix_sign_2) ? -product : product;
        quo_fixed  = (fix_sign_1 ^ fix_sign_2) ? -quotient : quotient;
        rem_fixed  = fix_sign_1 ? -remainder : remainder;
        case (fix_funct3)
            M_MUL:                      result = prod_fixed[DATA_WIDTH-1:0];
            M_MULH, M_MULHSU, M_MULHU:  result = prod_fixed[2*DATA_WIDTH-1:DATA_WIDTH];
            M_DIV, M_DIVU:              result = quo_fixed;
            default:                    result = rem_fixed;
        endcase
    end

endmodule

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a start/busy/done handshake.
module rv32_muldiv_unit
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [2:0]            funct3_in,
    input  logic [DATA_WIDTH-1:0] data_1_in,
    input  logic [DATA_WIDTH-1:0] data_2_in,
    input  logic                  flush_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] result_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    md_state_t state;

    logic [2:0]              funct3_q;
    logic                    sign_1_q;
    logic                    sign_2_q;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]   operand_q;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]        cnt;

    logic                  sign_1;
    logic                  sign_2;
    logic [DATA_WIDTH-1:0] mag_1;
    logic [DATA_WIDTH-1:0] mag_2;
    logic [DATA_WIDTH-1:0] fix_result;

    logic                  is_div_in;
    logic                  is_rem_in;
    logic                  div_zero;
    logic                  div_ovf;
    logic [DATA_WIDTH-1:0] special_result;

    logic [DATA_WIDTH-1:0] mul_addend;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  rem_ge;

    muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
        .funct3     (funct3_in),
        .data_1     (data_1_in),
        .data_2     (data_2_in),
        .sign_1     (sign_1),
        .sign_2     (sign_2),
        .mag_1      (mag_1),
        .mag_2      (mag_2),
        .fix_funct3 (funct3_q),
        .fix_sign_1 (sign_1_q),
        .fix_sign_2 (sign_2_q),
        .product    (acc),
        .quotient   (shreg),
        .remainder  (rem),
        .result     (fix_result)
    );

    always_comb begin
        is_div_in = funct3_in[2];
        is_rem_in = (funct3_in == M_REM) || (funct3_in == M_REMU);
        div_zero  = is_div_in && (data_2_in == '0);
        div_ovf   = ((funct3_in == M_DIV) || (funct3_in == M_REM))
                    && (data_1_in == SIGNED_MIN) && (data_2_in == '1);
        special_result = '0;
        if (div_zero)
            special_result = is_rem_in ? data_1_in : DIV_BY_ZERO_Q;
        else if (div_ovf)
            special_result = is_rem_in ? '0 : SIGNED_MIN;
    end

    // Remainder stays below the divisor, so the shifted value fits in W+1 bits and
    // the borrow of the W+1-bit difference is exactly "shifted < divisor".
    always_comb begin
        mul_addend = shreg[0] ? operand_q : '0;
        mul_sum    = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mul_addend};
        rem_shift  = {rem, shreg[DATA_WIDTH-1]};
        rem_diff   = rem_shift - {1'b0, operand_q};
        rem_ge     = ~rem_diff[DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MD_IDLE;
            cnt        <= '0;
            result_out <= '0;
            funct3_q   <= '0;
            sign_1_q   <= 1'b0;
            sign_2_q   <= 1'b0;
            acc        <= '0;
            rem        <= '0;
            operand_q  <= '0;
            shreg      <= '0;
        end else if (flush_in) begin
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    if (start_in) begin
                        funct3_q <= funct3_in;
                        sign_1_q <= sign_1;
                        sign_2_q <= sign_2;
                        cnt      <= '0;
                        acc      <= '0;
                        rem      <= '0;
                        // Divide shifts the dividend out of shreg; multiply shifts the multiplier.
                        if (is_div_in) begin
                            operand_q <= mag_2;
                            shreg     <= mag_1;
                        end else begin
                            operand_q <= mag_1;
                            shreg     <= mag_2;
                        end
                        if (div_zero || div_ovf) begin
                            result_out <= special_result;
                            state      <= MD_DONE;
                        end else begin
                            state <= MD_CALC;
                        end
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    if (funct3_q[2]) begin
                        rem   <= rem_ge ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
                        shreg <= {shreg[DATA_WIDTH-2:0], rem_ge};
                    end else begin
                        acc   <= {mul_sum, acc[DATA_WIDTH-1:1]};
                        shreg <= shreg >> 1;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST)
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    result_out <= fix_result;
                    state      <= MD_DONE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy_out = (state == MD_CALC) || (state == MD_FIX);
    assign done_out = (state == MD_DONE);

endmodule
